// File: rtl/freq_gen_pro.sv
// freq_gen_pro: programmable square-wave stimulus generator.
// Bursts of N periods or continuous, with start/busy/done handshake.
module freq_gen_pro #(
  parameter int WD = 14
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [31:0]          period,
  input  logic [31:0]          times,
  input  logic signed [WD-1:0] amplitude,
  output logic signed [WD-1:0] signal_out,
  output logic                 sq_out,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          cycle_cnt
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic signed [WD-1:0] AMIN = {1'b1, {(WD-1){1'b0}}};
  localparam logic signed [WD-1:0] AMAX = {1'b0, {(WD-1){1'b1}}};

  state_e state_q, state_d;
  logic [31:0] ph_q, ph_d;
  logic [31:0] per_q, per_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] times_q, times_d;
  logic [31:0] cnt_q, cnt_d;
  logic signed [WD-1:0] amp_q, amp_d;
  logic signed [WD-1:0] sig_q, sig_d;
  logic stop_q, stop_d;
  logic sq_q, sq_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [31:0] per_in, hi_in, ph_nx, cnt_inc;
  logic last_ph, stop_now, end_run;
  logic signed [WD-1:0] amp_lo;

  assign per_in   = (period < 32'd2) ? 32'd2 : period;
  assign hi_in    = per_in - (per_in >> 1);
  assign ph_nx    = ph_q + 32'd1;
  assign cnt_inc  = cnt_q + 32'd1;
  assign last_ph  = (ph_q == per_q - 32'd1);
  assign stop_now = stop_q | stop;
  assign end_run  = ((times_q != 32'd0) && (cnt_inc == times_q)) | stop_now;
  // Negating the most-negative level would wrap; clamp it instead.
  assign amp_lo   = (amp_q == AMIN) ? AMAX : -amp_q;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    per_d   = per_q;
    hi_d    = hi_q;
    times_d = times_q;
    cnt_d   = cnt_q;
    amp_d   = amp_q;
    stop_d  = stop_q;
    sig_d   = sig_q;
    sq_d    = sq_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        sig_d  = '0;
        sq_d   = 1'b0;
        busy_d = 1'b0;
        stop_d = 1'b0;
        if (start) begin
          state_d = RUN;
          per_d   = per_in;
          hi_d    = hi_in;
          amp_d   = amplitude;
          times_d = times;
          ph_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          sq_d    = 1'b1;
          sig_d   = amplitude;
        end
      end
      RUN: begin
        if (last_ph) begin
          cnt_d = cnt_inc;
          ph_d  = '0;
          per_d = per_in;
          hi_d  = hi_in;
          amp_d = amplitude;
          if (end_run) begin
            state_d = IDLE;
            stop_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            sq_d    = 1'b0;
            sig_d   = '0;
          end else begin
            stop_d = 1'b0;
            sq_d   = 1'b1;
            sig_d  = amplitude;
          end
        end else begin
          ph_d   = ph_nx;
          stop_d = stop_now;
          sq_d   = (ph_nx < hi_q);
          sig_d  = (ph_nx < hi_q) ? amp_q : amp_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ph_q    <= '0;
      per_q   <= '0;
      hi_q    <= '0;
      times_q <= '0;
      cnt_q   <= '0;
      amp_q   <= '0;
      stop_q  <= 1'b0;
      sig_q   <= '0;
      sq_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      times_q <= times_d;
      cnt_q   <= cnt_d;
      amp_q   <= amp_d;
      stop_q  <= stop_d;
      sig_q   <= sig_d;
      sq_q    <= sq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign signal_out = sig_q;
  assign sq_out     = sq_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_freq_gen_pro.sv
// tb_freq_gen_pro: directed + random bench for freq_gen_pro.
// Reference model expands each period into a queue of expected samples.
module tb_freq_gen_pro;

  localparam int WD = 14;
  localparam logic signed [WD-1:0] AMIN = {1'b1, {(WD-1){1'b0}}};
  localparam logic signed [WD-1:0] AMAX = {1'b0, {(WD-1){1'b1}}};

  logic clk = 1'b0;
  logic rstn;
  logic start, stop;
  logic [31:0] period, times;
  logic signed [WD-1:0] amplitude;
  logic signed [WD-1:0] signal_out;
  logic sq_out, busy, done;
  logic [31:0] cycle_cnt;

  freq_gen_pro #(.WD(WD)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .period(period), .times(times), .amplitude(amplitude),
    .signal_out(signal_out), .sq_out(sq_out), .busy(busy),
    .done(done), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic sq;
    logic signed [WD-1:0] sig;
    logic last;
  } samp_t;

  samp_t q[$];
  bit m_active, m_stop, m_last;
  int unsigned m_cnt, m_times;
  logic e_sq, e_busy, e_done;
  logic signed [WD-1:0] e_sig;

  function automatic void push_period(int unsigned p, logic signed [WD-1:0] a);
    int unsigned per;
    int unsigned hi;
    logic signed [WD-1:0] lo;
    per = (p < 2) ? 2 : p;
    hi  = (per + 1) / 2;
    lo  = (a == AMIN) ? AMAX : -a;
    for (int i = 0; i < int'(per); i++)
      q.push_back('{sq: (i < int'(hi)), sig: (i < int'(hi)) ? a : lo,
                    last: (i == int'(per) - 1)});
  endfunction

  function automatic void take();
    samp_t s;
    s = q.pop_front();
    e_sq = s.sq; e_sig = s.sig; e_busy = 1'b1; e_done = 1'b0;
    m_last = s.last;
  endfunction

  function automatic void idle(bit d);
    e_sq = 1'b0; e_sig = '0; e_busy = 1'b0; e_done = d; m_last = 1'b0;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_active = 0; m_stop = 0; m_cnt = 0;
    idle(0);
  endfunction

  // Expected outputs after the coming clock edge, from current inputs.
  function automatic void model_step();
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_cnt = 0; m_times = times; m_stop = 0;
        push_period(period, amplitude);
        take();
      end else idle(0);
    end else begin
      if (stop) m_stop = 1;
      if (m_last) begin
        m_cnt++;
        if ((m_times != 0 && m_cnt == m_times) || m_stop) begin
          m_active = 0; m_stop = 0;
          idle(1);
        end else begin
          push_period(period, amplitude);
          take();
        end
      end else take();
    end
  endfunction

  int n_busy, n_done, n_rise, cyc;
  int rises[$];
  logic prev_sq = 1'b0;

  task automatic clr_stats();
    n_busy = 0; n_done = 0; n_rise = 0;
    rises.delete();
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    chk("out", {sq_out, busy, done, signal_out}, {e_sq, e_busy, e_done, e_sig});
    chk("cnt", cycle_cnt, m_cnt);
    cyc++;
    if (busy) n_busy++;
    if (done) n_done++;
    if (sq_out && !prev_sq) begin n_rise++; rises.push_back(cyc); end
    prev_sq = sq_out;
    start = 0; stop = 0;
  endtask

  initial begin
    rstn = 0; start = 0; stop = 0;
    period = 4; times = 1; amplitude = 14'sd1000;
    cyc = 0;
    model_reset();
    #1;
    chk("rst", {sq_out, busy, done, signal_out, cycle_cnt}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    step();

    // single period
    clr_stats();
    period = 4; times = 1; amplitude = 14'sd1000; start = 1;
    repeat (6) step();
    chk("t1_busy", n_busy, 4);
    chk("t1_done", n_done, 1);
    chk("t1_cnt", cycle_cnt, 1);

    // odd period burst
    clr_stats();
    period = 5; times = 3; amplitude = -14'sd77; start = 1;
    repeat (18) step();
    chk("t2_busy", n_busy, 15);
    chk("t2_rise", n_rise, 3);
    chk("t2_done", n_done, 1);
    chk("t2_cnt", cycle_cnt, 3);

    // clamp + saturation
    clr_stats();
    period = 0; times = 2; amplitude = AMIN; start = 1;
    step();
    chk("t3_hi", signal_out, AMIN);
    step();
    chk("t3_lo", signal_out, AMAX);
    repeat (4) step();
    chk("t3_busy", n_busy, 4);
    chk("t3_done", n_done, 1);

    // continuous with stop; start during RUN ignored
    clr_stats();
    period = 10; times = 0; amplitude = 14'sd300; start = 1;
    step();
    for (int i = 0; i < 63; i++) begin
      if (i == 20) begin start = 1; times = 1; end
      step();
    end
    stop = 1;
    repeat (10) step();
    chk("t4_cnt", cycle_cnt, 7);
    chk("t4_done", n_done, 1);
    chk("t4_busy", n_busy, 70);

    // live period/amplitude update
    clr_stats();
    period = 8; times = 0; amplitude = 14'sd500; start = 1;
    repeat (3) step();
    period = 6; amplitude = 14'sd700;
    repeat (25) step();
    stop = 1;
    repeat (10) step();
    if (rises.size() >= 3) begin
      chk("t5_p1", rises[1] - rises[0], 8);
      chk("t5_p2", rises[2] - rises[1], 6);
    end else chk("t5_rises", rises.size(), 3);

    // async reset mid-run
    clr_stats();
    period = 8; times = 0; amplitude = 14'sd1234; start = 1;
    repeat (3) step();
    rstn = 0;
    #1;
    chk("t6_rst", {sq_out, busy, done, signal_out, cycle_cnt}, 0);
    model_reset();
    @(posedge clk); #1;
    chk("t6_hold", {sq_out, busy, done, signal_out}, 0);
    rstn = 1;
    clr_stats();
    period = 3; times = 2; amplitude = 14'sd55; start = 1;
    repeat (8) step();
    chk("t6_done", n_done, 1);
    chk("t6_cnt", cycle_cnt, 2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom % 6) == 0;
      stop  = ($urandom % 40) == 0;
      if ($urandom % 25 == 0) period = $urandom % 13;
      if ($urandom % 25 == 0) times = $urandom % 5;
      if ($urandom % 25 == 0)
        amplitude = ($urandom % 4 == 0) ? AMIN : WD'($urandom);
      step();
    end
    for (int i = 0; i < 40 && busy; i++) begin
      stop = 1;
      step();
    end
    chk("drain", busy, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/freq_gen_pro.md
Name: freq_gen_pro

Overview:
- Programmable square-wave stimulus generator: emits a signed WD-bit two-level waveform (+amplitude / −amplitude) with a period given in clk cycles.
- Runs for a programmed number of periods, or continuously.
- Sits in front of the DAC path / loopback. It is the transmit-side counterpart of the frequency-measurement path: every output period starts with exactly one rising edge.
- Provides start/busy/done handshaking for the control FSM.

Parameters:
- WD, 14, width of signed sample output and amplitude input.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- stop  input  1  graceful stop request; honoured at the next period boundary
- period  input  32  clk cycles per output period; values <2 treated as 2
- times  input  32  number of periods to emit; 0 = continuous
- amplitude  input  signed WD  output level magnitude
- signal_out  output  signed WD  generated sample, registered
- sq_out  output  1  square-wave logic level, registered
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a run ends
- cycle_cnt  output  32  completed periods in the current or last run

Behaviour:
- Reset (async, rstn=0): state IDLE; signal_out=0, sq_out=0, busy=0, done=0, cycle_cnt=0; internal phase counter, shadow registers and stop flag are cleared.
- Shadow registers:
  - per_s = max(period, 2); hi_s = per_s − (per_s>>1), so high gets the extra cycle on odd periods; amp_s = amplitude.
  - Loaded on an accepted start and again at every period boundary.
  - times is latched only on start.
- States: IDLE, RUN.
- IDLE behaviour:
  - signal_out=0, sq_out=0, busy=0.
  - start=1 sampled at edge k → load shadows, ph=0, cycle_cnt=0.
  - From edge k+1 (registered): state RUN, busy=1, sq_out=1, signal_out=+amp_s.
- RUN phase counter:
  - ph counts 0..per_s−1.
  - sq_out=1 while ph<hi_s, else 0.
  - signal_out=+amp_s when high, −amp_s when low.
  - If amp_s is the most-negative value, −amp_s saturates to the most-positive value.
- Period boundary (ph==per_s−1):
  - cycle_cnt increments; ph wraps to 0; shadows reload.
  - End condition: (times≠0 and cycle_cnt+1==times) or stop flag set.
  - End → next cycle IDLE, busy=0, done=1 for exactly one cycle, signal_out=0, sq_out=0. cycle_cnt holds its final value until the next start.
  - No end → new period begins with sq_out=1, giving exactly one rising edge per period.
- stop:
  - stop=1 in RUN sets a sticky flag; the flag clears on entry to IDLE.
  - stop in IDLE is ignored.
  - stop on the boundary cycle itself ends the run at that boundary.
- start while RUN is ignored.
- start and stop asserted together in IDLE: start accepted, stop ignored.
- Live parameter changes:
  - period/amplitude changes in RUN take effect only at the next boundary; the current period is never truncated.
  - times changes in RUN have no effect.
- cycle_cnt wraps modulo 2^32 in continuous mode, with no flag.
- Reset mid-run: immediate return to IDLE values. No done pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Single period: period=4, times=1, amplitude=1000, start pulse → from cycle +1: sq_out 1,1,0,0 and signal_out +1000,+1000,−1000,−1000. Then done=1 for one cycle, busy=0, cycle_cnt=1, signal_out=0.
- Odd period/burst: period=5, times=3 → three periods, each high 3 / low 2 cycles, 3 rising edges. busy high exactly 15 cycles, cycle_cnt=3, done once.
- Clamp and saturation: period=0, times=2, amplitude=−8192 (WD=14) → period of 2 cycles (1 high, 1 low). Low level = +8191, high level = −8192. Run ends after 4 cycles.
- Continuous and stop: times=0, period=10. Assert stop at ph=3 of period 7 → period 7 completes in full, done fires, cycle_cnt=7. A start during RUN is ignored.
- Live update: period=8 running with times=0; change period to 6 mid-period → current period stays 8 cycles, the following periods are 6 cycles. The amplitude change 500→700 applies from the next period start.
- Async reset mid-run (rstn low at ph=2) → all outputs 0 immediately, no done pulse. After release, a new start runs normally.
